row_sequencer: RTL and testbench

ROW_SEQUENCER -- requirements
Module: row_sequencer

---
 rtl/row_sequencer.sv | 92 +++++++++
 tb/tb_row_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/row_sequencer.sv
// Four independent row sequencers: pop a row length, then issue one element request per nonzero.
// Optional ROW_SEQ_PREFETCH_EN pops the next length on the completing handshake of a row.
module row_sequencer #(
   parameter int LEN_W = 8,
   parameter int ROW_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [4*LEN_W-1:0] len_in,
   input  logic [3:0]         len_empty,
   output logic [3:0]         len_read,
   output logic [3:0]         elem_valid,
   input  logic [3:0]         elem_ready,
   output logic [3:0]         elem_last,
   output logic [4*ROW_W-1:0] row_idx,
   output logic [3:0]         row_done,
   output logic [3:0]         row_empty
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

   for (genvar g = 0; g < 4; g++) begin : lane
      state_t           state;
      logic [LEN_W-1:0] cnt;
      logic [LEN_W-1:0] len;
      logic [ROW_W-1:0] idx;
      logic             done_q;
      logic             empty_q;
      logic             hs;
      logic             fin;
      logic             pop;

      assign len = len_in[g*LEN_W +: LEN_W];
      assign hs  = (state == RUN) && elem_ready[g];
      assign fin = hs && (cnt == LEN_W'(1));

      // rst gating keeps the pop request low while reset holds the lane in IDLE
`ifdef ROW_SEQ_PREFETCH_EN
      assign pop = rst && !len_empty[g] && ((state == IDLE) || fin);
`else
      assign pop = rst && !len_empty[g] && (state == IDLE);
`endif

      assign len_read[g]   = pop;
      assign elem_valid[g] = (state == RUN);
      assign elem_last[g]  = (state == RUN) && (cnt == LEN_W'(1));
      assign row_done[g]   = done_q;
      assign row_empty[g]  = empty_q;
      assign row_idx[g*ROW_W +: ROW_W] = idx;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            done_q  <= 1'b0;
            empty_q <= 1'b0;
         end else begin
            done_q  <= 1'b0;
            empty_q <= 1'b0;
            case (state)
               IDLE: begin
                  if (pop) state <= LOAD;
               end
               LOAD: begin
                  cnt <= len;
                  if (len == '0) begin
                     state   <= IDLE;
                     idx     <= idx + ROW_W'(1);
                     done_q  <= 1'b1;
                     empty_q <= 1'b1;
                  end else begin
                     state <= RUN;
                  end
               end
               RUN: begin
                  if (hs) begin
                     cnt <= cnt - LEN_W'(1);
                     if (fin) begin
                        idx    <= idx + ROW_W'(1);
                        done_q <= 1'b1;
                        state  <= pop ? LOAD : IDLE;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_row_sequencer.sv
// Directed bench for row_sequencer: per-cycle vector table plus multi-cycle corner sequences.
module tb_row_sequencer;
   localparam int LEN_W = 8;
   localparam int ROW_W = 4;
`ifdef ROW_SEQ_PREFETCH_EN
   localparam int GAP = 2;
`else
   localparam int GAP = 3;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] len_in = '0;
   logic [3:0]  len_empty;
   logic [3:0]  len_read;
   logic [3:0]  elem_valid;
   logic [3:0]  elem_ready;
   logic [3:0]  elem_last;
   logic [15:0] row_idx;
   logic [3:0]  row_done;
   logic [3:0]  row_empty;

   int total = 0;
   int bad   = 0;

   logic [7:0] mem [4][256];
   logic [7:0] wp [4] = '{default: 8'd0};
   logic [7:0] rp [4] = '{default: 8'd0};

   always #5 clk = ~clk;

   row_sequencer #(.LEN_W(LEN_W), .ROW_W(ROW_W)) dut (
      .clk(clk), .rst(rst), .len_in(len_in), .len_empty(len_empty), .len_read(len_read),
      .elem_valid(elem_valid), .elem_ready(elem_ready), .elem_last(elem_last),
      .row_idx(row_idx), .row_done(row_done), .row_empty(row_empty)
   );

   // Length FIFO model: data appears on len_in the cycle after the pop
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (len_read[i]) begin
            len_in[i*8 +: 8] <= mem[i][rp[i]];
            rp[i] <= rp[i] + 8'd1;
         end
      end
   end

   always_comb begin
      len_empty = '1;
      for (int i = 0; i < 4; i++) len_empty[i] = (wp[i] == rp[i]);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) check("read_while_empty", {28'd0, len_read & len_empty}, 32'd0);

   task automatic push(input int lane, input logic [7:0] len);
      mem[lane][wp[lane]] = len;
      wp[lane] = wp[lane] + 8'd1;
   endtask

   typedef struct {
      logic [3:0]  ready;
      logic [3:0]  rd;
      logic [3:0]  vld;
      logic [3:0]  last;
      logic [3:0]  done;
      logic [3:0]  emp;
      logic [15:0] idx;
   } vec_t;

   vec_t tbl [8];
   int   hs;
   int   nd;
   int   nl;
   int   pos [3];
   int   vc [4];
   bit   seen;

   initial begin
      // cycle 0 = negedge at reset release; lane0 len 3, lane1 len 0, lane2 len 2 with toggling ready
      tbl[0] = '{4'h1, 4'h7, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000};
      tbl[1] = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000};
      tbl[2] = '{4'h1, 4'h0, 4'h5, 4'h0, 4'h2, 4'h2, 16'h0010};
      tbl[3] = '{4'h5, 4'h0, 4'h5, 4'h0, 4'h0, 4'h0, 16'h0010};
      tbl[4] = '{4'h1, 4'h0, 4'h5, 4'h5, 4'h0, 4'h0, 16'h0010};
      tbl[5] = '{4'h5, 4'h0, 4'h4, 4'h4, 4'h1, 4'h0, 16'h0011};
      tbl[6] = '{4'h5, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 16'h0111};
      tbl[7] = '{4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0111};

      rst = 1'b0;
      elem_ready = '0;
      repeat (3) @(negedge clk);
      push(0, 8'd3); push(1, 8'd0); push(2, 8'd2);
      #1;
      check("rst_read",  {28'd0, len_read},   32'd0);
      check("rst_valid", {28'd0, elem_valid}, 32'd0);
      check("rst_last",  {28'd0, elem_last},  32'd0);
      check("rst_done",  {28'd0, row_done},   32'd0);
      check("rst_empty", {28'd0, row_empty},  32'd0);
      check("rst_idx",   {16'd0, row_idx},    32'd0);

      @(negedge clk);
      rst = 1'b1;
      hs = 0;
      for (int k = 0; k < 8; k++) begin
         elem_ready = tbl[k].ready;
         #1;
         check($sformatf("t%0d_read", k),  {28'd0, len_read},   {28'd0, tbl[k].rd});
         check($sformatf("t%0d_valid", k), {28'd0, elem_valid}, {28'd0, tbl[k].vld});
         check($sformatf("t%0d_last", k),  {28'd0, elem_last},  {28'd0, tbl[k].last});
         check($sformatf("t%0d_done", k),  {28'd0, row_done},   {28'd0, tbl[k].done});
         check($sformatf("t%0d_empty", k), {28'd0, row_empty},  {28'd0, tbl[k].emp});
         check($sformatf("t%0d_idx", k),   {16'd0, row_idx},    {16'd0, tbl[k].idx});
         if (elem_valid[2] && elem_ready[2]) hs++;
         @(negedge clk);
      end
      check("lane2_handshakes", hs, 2);

      // throughput: three length-1 rows on every lane
      rst = 1'b0;
      elem_ready = 4'hF;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         push(i, 8'd1); push(i, 8'd1); push(i, 8'd1);
         vc[i] = 0;
      end
      @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 30; c++) begin
         #1;
         for (int i = 0; i < 4; i++) begin
            if (elem_valid[i]) begin
               if (i == 0 && vc[0] < 3) pos[vc[0]] = c;
               vc[i]++;
            end
         end
         @(negedge clk);
      end
      for (int i = 0; i < 4; i++) check($sformatf("thr_count_l%0d", i), vc[i], 3);
      check("thr_first", pos[0], 2);
      check("thr_gap1", pos[1] - pos[0], GAP);
      check("thr_gap2", pos[2] - pos[1], GAP);
      check("thr_idx", {16'd0, row_idx}, 32'h3333);

      // reset while lane 0 is mid-row with cnt=5
      rst = 1'b0;
      elem_ready = '0;
      @(negedge clk);
      push(0, 8'd8);
      @(negedge clk);
      rst = 1'b1;
      seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         if (elem_valid[0]) seen = 1;
      end
      check("mid_enter_run", seen, 1);
      elem_ready = 4'h1;
      repeat (3) @(negedge clk);
      elem_ready = '0;
      #1;
      check("mid_valid_before", {31'd0, elem_valid[0]}, 32'd1);
      check("mid_last_before",  {31'd0, elem_last[0]},  32'd0);
      rst = 1'b0;
      #1;
      check("mid_valid_drop", {28'd0, elem_valid}, 32'd0);
      check("mid_idx_clear",  {16'd0, row_idx},    32'd0);
      check("mid_read_low",   {28'd0, len_read},   32'd0);
      push(0, 8'd2);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      elem_ready = 4'hF;
      hs = 0;
      nd = 0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (elem_valid[0]) hs++;
         if (row_done[0]) nd++;
         @(negedge clk);
      end
      check("mid_after_hs",   hs, 2);
      check("mid_after_done", nd, 1);
      check("mid_after_idx",  {28'd0, row_idx[3:0]}, 32'd1);

      // sixteen length-1 rows on lane 3: row index wraps 15 -> 0
      rst = 1'b0;
      @(negedge clk);
      for (int r = 0; r < 16; r++) push(3, 8'd1);
      @(negedge clk);
      rst = 1'b1;
      nd = 0;
      for (int c = 0; c < 120; c++) begin
         #1;
         if (row_done[3]) begin
            nd++;
            if (nd == 15) check("wrap_idx15", {28'd0, row_idx[15:12]}, 32'd15);
            if (nd == 16) check("wrap_idx0",  {28'd0, row_idx[15:12]}, 32'd0);
         end
         @(negedge clk);
      end
      check("wrap_done_count", nd, 16);

      // maximum-length row on lane 1
      rst = 1'b0;
      @(negedge clk);
      push(1, 8'd255);
      @(negedge clk);
      rst = 1'b1;
      hs = 0;
      nl = 0;
      seen = 0;
      for (int c = 0; c < 400 && !seen; c++) begin
         #1;
         if (elem_valid[1]) hs++;
         if (elem_last[1]) nl++;
         if (row_done[1]) seen = 1;
         @(negedge clk);
      end
      check("max_done",  seen, 1);
      check("max_hs",    hs, 255);
      check("max_last",  nl, 1);
      check("max_idx",   {28'd0, row_idx[7:4]}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
